// File: rtl/key_cond_pkg.sv
// Shared types and helpers for the push-button conditioner.
package key_cond_pkg;

  typedef enum logic [1:0] {IDLE, HELD, REPEAT} rep_state_t;

  // Clocks per 1 ms timebase tick.
  function automatic int ms_div(input int clk_hz);
    return clk_hz / 1000;
  endfunction

endpackage

// File: rtl/key_channel.sv
// One button: 2-flop sync, tick-based debounce, press/release/toggle and auto-repeat FSM.
module key_channel
  import key_cond_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20,
  parameter int HOLD_MS     = 800,
  parameter int REPEAT_MS   = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic ms_tick,
  input  logic key_n,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_repeat,
  output logic key_toggle
);

  localparam int DW   = $clog2(DEBOUNCE_MS + 1);
  localparam int HMAX = (HOLD_MS > REPEAT_MS) ? HOLD_MS : REPEAT_MS;
  localparam int HW   = $clog2(HMAX + 1);

  logic [1:0]    sync_q;
  logic          stable_q;
  logic [DW-1:0] deb_q;
  rep_state_t    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          rep_d;

  logic pressed, differ, deb_done, acc_press, acc_release;

  assign pressed     = ~sync_q[1];
  assign differ      = pressed != stable_q;
  // The tick that completes DEBOUNCE_MS consecutive disagreeing samples.
  assign deb_done    = ms_tick && differ && (deb_q == DW'(DEBOUNCE_MS - 1));
  assign acc_press   = deb_done && pressed;
  assign acc_release = deb_done && !pressed;
  assign key_level   = stable_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= 2'b11;
      stable_q    <= 1'b0;
      deb_q       <= '0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_repeat  <= 1'b0;
      key_toggle  <= 1'b0;
      state_q     <= IDLE;
      hold_q      <= '0;
    end else begin
      sync_q <= {sync_q[0], key_n};
      if (ms_tick) begin
        if (!differ) begin
          deb_q <= '0;
        end else if (deb_done) begin
          deb_q    <= '0;
          stable_q <= pressed;
        end else begin
          deb_q <= deb_q + 1'b1;
        end
      end
      key_press   <= acc_press;
      key_release <= acc_release;
      key_repeat  <= rep_d;
      if (acc_press) key_toggle <= ~key_toggle;
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // A release in HELD/REPEAT takes priority over a repeat due on the same tick.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    rep_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc_press) begin
          state_d = HELD;
          hold_d  = '0;
          rep_d   = 1'b1;
        end
      end
      HELD: begin
        if (acc_release) begin
          state_d = IDLE;
          hold_d  = '0;
        end else if (ms_tick) begin
          if (hold_q == HW'(HOLD_MS - 1)) begin
            state_d = REPEAT;
            hold_d  = '0;
            rep_d   = 1'b1;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      REPEAT: begin
        if (acc_release) begin
          state_d = IDLE;
          hold_d  = '0;
        end else if (ms_tick) begin
          if (hold_q == HW'(REPEAT_MS - 1)) begin
            hold_d = '0;
            rep_d  = 1'b1;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
      end
    endcase
  end

endmodule

// File: rtl/key_conditioner.sv
// Button front-end: 1 ms timebase shared by N_KEYS independent key channels.
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int N_KEYS      = 5,
  parameter int DEBOUNCE_MS = 20,
  parameter int HOLD_MS     = 800,
  parameter int REPEAT_MS   = 200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_repeat,
  output logic [N_KEYS-1:0] key_toggle,
  output logic              ms_tick
);

  localparam int MS_DIV = ms_div(CLK_HZ);
  localparam int CW     = $clog2(MS_DIV + 1);

  logic [CW-1:0] div_q;

  assign ms_tick = (div_q == CW'(MS_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst)          div_q <= '0;
    else if (ms_tick) div_q <= '0;
    else              div_q <= div_q + 1'b1;
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_channel #(
      .DEBOUNCE_MS(DEBOUNCE_MS),
      .HOLD_MS    (HOLD_MS),
      .REPEAT_MS  (REPEAT_MS)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .ms_tick    (ms_tick),
      .key_n      (key_n[i]),
      .key_level  (key_level[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .key_repeat (key_repeat[i]),
      .key_toggle (key_toggle[i])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench: stimulus queues expected pulse events tagged with their deciding tick.
module tb_key_conditioner;

  localparam int NK  = 5;
  localparam int DIV = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] key_n = '1;
  logic [NK-1:0] key_level, key_press, key_release, key_repeat, key_toggle;
  logic          ms_tick;

  always #5 clk = ~clk;

  key_conditioner #(
    .CLK_HZ(10_000), .N_KEYS(NK), .DEBOUNCE_MS(4), .HOLD_MS(10), .REPEAT_MS(3)
  ) dut (
    .clk(clk), .rst(rst), .key_n(key_n),
    .key_level(key_level), .key_press(key_press), .key_release(key_release),
    .key_repeat(key_repeat), .key_toggle(key_toggle), .ms_tick(ms_tick)
  );

  typedef struct {
    int            tick;
    logic [NK-1:0] prs, rel, rpt, lvl, tgl;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0, n_bad = 0;
  int   cnt_m = 0, tick_cnt = 0, dec_tick = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int t, input logic [NK-1:0] p, r, rp, l, tg);
    exp_t e;
    e.tick = t; e.prs = p; e.rel = r; e.rpt = rp; e.lvl = l; e.tgl = tg;
    sb.push_back(e);
  endtask

  // Timebase reference: dec_tick names the tick whose effects are visible this cycle.
  always @(posedge clk) begin
    if (rst) begin
      cnt_m = 0; tick_cnt = 0; dec_tick = -1;
    end else begin
      dec_tick = (cnt_m == DIV - 1) ? tick_cnt + 1 : -1;
      if (cnt_m == DIV - 1) begin
        cnt_m = 0;
        tick_cnt++;
      end else begin
        cnt_m++;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    check("ms_tick", 64'(ms_tick), 64'(cnt_m == DIV - 1));
    if (|{key_press, key_release, key_repeat}) begin
      if (sb.size() == 0) begin
        check($sformatf("unexpected_pulse@t%0d", dec_tick),
              64'({key_press, key_release, key_repeat}), 64'd0);
      end else begin
        e = sb.pop_front();
        check($sformatf("event@t%0d", e.tick),
              64'({dec_tick, key_press, key_release, key_repeat, key_level, key_toggle}),
              64'({e.tick, e.prs, e.rel, e.rpt, e.lvl, e.tgl}));
      end
    end
  end

  // Returns in the cycle right after tick k's deciding clock.
  task automatic goto(input int k);
    int g = 0;
    while (tick_cnt < k && g < 5000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 5000) begin
      n_cmp++; n_bad++;
      $display("FAIL goto_timeout: tick %0d expected %0d", tick_cnt, k);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs",
          64'({key_level, key_press, key_release, key_repeat, key_toggle, ms_tick}), 64'd0);
    rst = 1'b0;

    // Clean press of key 0, released after 6 ms.
    goto(1);  key_n[0] = 1'b0; push(5, 5'b00001, 5'b0, 5'b00001, 5'b00001, 5'b00001);
    goto(7);  key_n[0] = 1'b1; push(11, 5'b0, 5'b00001, 5'b0, 5'b0, 5'b00001);

    // Bouncing key 1.
    goto(12); key_n[1] = 1'b0;
    goto(13); key_n[1] = 1'b1;
    goto(14); key_n[1] = 1'b0; push(18, 5'b00010, 5'b0, 5'b00010, 5'b00010, 5'b00011);
    goto(16); check("k1_level_during_bounce", 64'(key_level[1]), 64'd0);
    goto(19); key_n[1] = 1'b1; push(23, 5'b0, 5'b00010, 5'b0, 5'b0, 5'b00011);

    // Short glitch on key 2 is discarded.
    goto(24); key_n[2] = 1'b0;
    goto(27); key_n[2] = 1'b1;
    goto(30);
    check("k2_level_after_glitch", 64'(key_level[2]), 64'd0);
    check("k2_toggle_after_glitch", 64'(key_toggle[2]), 64'd0);

    // Long hold on key 3: repeats at 44,47,..,56; the repeat due at 59 loses to release.
    key_n[3] = 1'b0; push(34, 5'b01000, 5'b0, 5'b01000, 5'b01000, 5'b01011);
    for (int t = 44; t <= 56; t += 3) push(t, 5'b0, 5'b0, 5'b01000, 5'b01000, 5'b01011);
    goto(55); key_n[3] = 1'b1; push(59, 5'b0, 5'b01000, 5'b0, 5'b0, 5'b01011);

    // Simultaneous keys 0 and 4; key 0 toggle returns to 0.
    goto(60); key_n[0] = 1'b0; key_n[4] = 1'b0;
    push(64, 5'b10001, 5'b0, 5'b10001, 5'b10001, 5'b11010);
    goto(65); key_n[0] = 1'b1; push(69, 5'b0, 5'b00001, 5'b0, 5'b10000, 5'b11010);

    // Reset pulse while key 4 is held.
    goto(71);
    check("pre_reset_level", 64'(key_level), 64'(5'b10000));
    check("pre_reset_toggle", 64'(key_toggle), 64'(5'b11010));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("post_reset_outputs",
          64'({key_level, key_press, key_release, key_repeat, key_toggle, ms_tick}), 64'd0);
    push(4, 5'b10000, 5'b0, 5'b10000, 5'b10000, 5'b10000);
    goto(5);  key_n[4] = 1'b1; push(9, 5'b0, 5'b10000, 5'b0, 5'b0, 5'b10000);
    goto(12);
    check("events_outstanding", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
